// File: rtl/piso_pkg.sv
// Shared types and constants for the parallel-in/serial-out shifter.
// PISO_PARITY_EN selects whether an even-parity bit trails each word.
package piso_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } piso_state_t;

    localparam logic SERIAL_IDLE_LEVEL = 1'b1;

`ifdef PISO_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

endpackage

// File: rtl/piso_shifter.sv
// Parallel-in/serial-out shift datapath with bit counting, done/overrun pulses.
// Optional trailing even-parity bit when PISO_PARITY_EN is defined.
module piso_shifter
    import piso_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int MSB_FIRST  = 1,
    localparam int BLW       = $clog2(DATA_WIDTH + 2)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  shift,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  serial_out,
    output logic                  busy,
    output logic                  done,
    output logic                  overrun,
    output logic [BLW-1:0]        bits_left
);

    // Parity, when enabled, rides in the shift register behind the data bits.
    localparam int SW = DATA_WIDTH + PARITY_BITS;
    localparam logic [BLW-1:0] NBITS = BLW'(SW);

    piso_state_t   state_q, state_d;
    logic [SW-1:0] sreg_q, sreg_d;
    logic [SW-1:0] load_word;
    logic [BLW-1:0] bits_left_q, bits_left_d;
    logic          serial_out_q, serial_out_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          overrun_q, overrun_d;

`ifdef PISO_PARITY_EN
    assign load_word = (MSB_FIRST != 0) ? {data_in, ^data_in} : {^data_in, data_in};
`else
    assign load_word = data_in;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            sreg_q       <= '0;
            bits_left_q  <= '0;
            serial_out_q <= SERIAL_IDLE_LEVEL;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sreg_q       <= sreg_d;
            bits_left_q  <= bits_left_d;
            serial_out_q <= serial_out_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            overrun_q    <= overrun_d;
        end
    end

    // Load always wins over shift; shift is only meaningful while ACTIVE.
    always_comb begin
        state_d     = state_q;
        sreg_d      = sreg_q;
        bits_left_d = bits_left_q;
        if (load) begin
            state_d     = ACTIVE;
            sreg_d      = load_word;
            bits_left_d = NBITS;
        end else if (shift && state_q == ACTIVE) begin
            if (MSB_FIRST != 0) begin
                sreg_d = {sreg_q[SW-2:0], 1'b0};
            end else begin
                sreg_d = {1'b0, sreg_q[SW-1:1]};
            end
            bits_left_d = bits_left_q - 1'b1;
            if (bits_left_q == BLW'(1)) begin
                state_d = IDLE;
            end
        end
    end

    always_comb begin
        overrun_d    = load && (state_q == ACTIVE);
        done_d       = !load && shift && (state_q == ACTIVE) && (bits_left_q == BLW'(1));
        busy_d       = (state_d == ACTIVE);
        serial_out_d = SERIAL_IDLE_LEVEL;
        if (state_d == ACTIVE) begin
            serial_out_d = (MSB_FIRST != 0) ? sreg_d[SW-1] : sreg_d[0];
        end
    end

    assign serial_out = serial_out_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign overrun    = overrun_q;
    assign bits_left  = bits_left_q;

endmodule
